// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer pixel/word types and MIG byte-address mapping
package fb_pkg;

  typedef logic [15:0]      pixel_t;
  typedef logic [7:0][15:0] mig_word_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } scan_state_t;

  localparam int MIG_ADDR_W     = 27;
  localparam int BYTES_PER_WORD = 16;
  localparam int ADDR_LSB       = $clog2(BYTES_PER_WORD);
  localparam int WORD_IDX_W     = MIG_ADDR_W - 2 - ADDR_LSB;

  // Byte address of one 128-bit word: {pad, frame, word_idx, byte offset}
  function automatic logic [MIG_ADDR_W-1:0] fb_word_addr(input logic frame,
                                                        input logic [WORD_IDX_W-1:0] word_idx);
    return {1'b0, frame, word_idx, {ADDR_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/mig_word_unpacker.sv
// rtl/mig_word_unpacker.sv - 128-bit MIG word to 16-bit pixel serializer
module mig_word_unpacker
  import fb_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  mig_word_t word_tdata,
  input  logic      word_tvalid,
  output logic      word_tready,
  output pixel_t    pixel_tdata,
  output logic      pixel_tvalid,
  input  logic      pixel_tready,
  output logic      word_done
);

  mig_word_t  word_q;
  logic [2:0] lane_q;
  logic       full_q;
  logic       pix_hs;
  logic       last_lane;

  assign last_lane    = (lane_q == 3'd7);
  assign pix_hs       = full_q && pixel_tready;
  assign word_done    = pix_hs && last_lane;
  // A new word may load in the same cycle the last lane leaves, keeping one pixel per cycle
  assign word_tready  = !full_q || word_done;
  assign pixel_tvalid = full_q;
  assign pixel_tdata  = word_q[lane_q];

  // Hold one word and step through its lanes on each downstream handshake
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_q <= '0;
      lane_q <= 3'd0;
      full_q <= 1'b0;
    end else begin
      if (pix_hs) begin
        lane_q <= lane_q + 3'd1;
        if (last_lane) begin
          full_q <= 1'b0;
        end
      end
      if (word_tvalid && word_tready) begin
        word_q <= word_tdata;
        full_q <= 1'b1;
        lane_q <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/mig_read_scanout.sv
// rtl/mig_read_scanout.sv - raster-order framebuffer scanout over MIG read requests
module mig_read_scanout
  import fb_pkg::*;
#(
  parameter int HRES            = 320,
  parameter int VRES            = 180,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    frame_in,
  output logic                    req_valid_out,
  output logic [MIG_ADDR_W-1:0]   req_addr_out,
  input  logic                    req_rdy_in,
  input  logic                    resp_valid_in,
  input  logic [127:0]            resp_data_in,
  output logic                    resp_rdy_out,
  output logic                    pixel_valid_out,
  output logic [15:0]             pixel_out,
  output logic [$clog2(HRES)-1:0] hcount_out,
  output logic [$clog2(VRES)-1:0] vcount_out,
  input  logic                    pixel_rdy_in,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int WORDS = HRES * VRES / 8;
  localparam int HW    = $clog2(HRES);
  localparam int VW    = $clog2(VRES);
  localparam int RW    = $clog2(WORDS + 1);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  scan_state_t   state_q;
  logic          frame_q;
  logic          busy_q;
  logic          done_q;
  logic          drop_rdy_q;
  logic [RW-1:0] req_cnt_q;
  logic [CW-1:0] credits_q;
  logic [HW-1:0] hcount_q;
  logic [VW-1:0] vcount_q;

  logic   run;
  logic   req_hs;
  logic   unpack_tvalid;
  logic   unpack_tready;
  logic   pix_valid;
  logic   pix_hs;
  logic   word_done;
  logic   last_pixel;
  pixel_t pix_data;

  assign run           = (state_q == S_RUN);
  assign req_valid_out = run && (req_cnt_q < RW'(WORDS)) && (credits_q < CW'(MAX_OUTSTANDING));
  assign req_addr_out  = fb_word_addr(frame_q, WORD_IDX_W'(req_cnt_q));
  assign req_hs        = req_valid_out && req_rdy_in;

  // Outside a frame every response is accepted and thrown away, flushing stale MIG data
  assign unpack_tvalid = run && resp_valid_in;
  assign resp_rdy_out  = run ? unpack_tready : drop_rdy_q;

  assign pixel_valid_out = pix_valid;
  assign pixel_out       = pix_data;
  assign pix_hs          = pix_valid && pixel_rdy_in;
  assign last_pixel      = (hcount_q == HW'(HRES - 1)) && (vcount_q == VW'(VRES - 1));

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;

  mig_word_unpacker u_unpacker (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .word_tdata   (resp_data_in),
    .word_tvalid  (unpack_tvalid),
    .word_tready  (unpack_tready),
    .pixel_tdata  (pix_data),
    .pixel_tvalid (pix_valid),
    .pixel_tready (pixel_rdy_in),
    .word_done    (word_done)
  );

  // Frame FSM with request counter, outstanding-word credits and raster position
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_rdy_q <= 1'b0;
      req_cnt_q  <= '0;
      credits_q  <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
    end else begin
      drop_rdy_q <= 1'b1;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            frame_q   <= frame_in;
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            req_cnt_q <= '0;
            credits_q <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
          end
        end
        S_RUN: begin
          if (req_hs) begin
            req_cnt_q <= req_cnt_q + RW'(1);
          end
          case ({req_hs, word_done})
            2'b10:   credits_q <= credits_q + CW'(1);
            2'b01:   credits_q <= credits_q - CW'(1);
            default: credits_q <= credits_q;
          endcase
          if (pix_hs) begin
            if (last_pixel) begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              req_cnt_q <= '0;
              credits_q <= '0;
              hcount_q  <= '0;
              vcount_q  <= '0;
            end else if (hcount_q == HW'(HRES - 1)) begin
              hcount_q <= '0;
              vcount_q <= vcount_q + VW'(1);
            end else begin
              hcount_q <= hcount_q + HW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
